fmul_pipe: RTL and testbench

//  Parametrised, elastic IEEE-754-style floating-point multiplier, successor to the fixed 2-stage fp32 fmul.

---
 rtl/fpu_pkg.sv | 40 ++++
 rtl/fmul_round.sv | 92 +++++++++
 rtl/fmul_pipe.sv | 127 ++++++++++++
 tb/tb_fmul_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: types and helpers shared by the FPU datapath blocks.
//   FP32_EXP_W / FP32_MAN_W : field widths of IEEE-754 binary32
//   fp_flags_t              : exception flags {nv, of, uf, nx}
//   fp_class_t              : operand class (ZERO covers subnormals, which are flushed)
//   fp_classify()           : class from pre-decoded exponent/mantissa tests
//   bias()                  : exponent bias for a given exponent width
package fpu_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_t;

  // Width-agnostic: the caller reduces its own fields to the three tests.
  function automatic fp_class_t fp_classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic man_zero);
    if (exp_zero)      return ZERO;
    else if (!exp_ones) return NORM;
    else if (man_zero)  return INF;
    else                return NAN;
  endfunction

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fmul_round.sv
// fmul_round: combinational last-stage logic of the multiplier.
//   Normalises the raw significand product, rounds to nearest even, packs the
//   result and raises exception flags, with special operands taking priority.
// Ports:
//   sign_i   : product sign (s1 ^ s2)
//   esum_i   : e1 + e2, EXP_W+2 bits, two's complement
//   prod_i   : {1,m1} * {1,m2}, 2*MAN_W+2 bits
//   cls_a_i  : class of operand A
//   cls_b_i  : class of operand B
//   y_o      : packed result {sign, exp, man}
//   flags_o  : {nv, of, uf, nx}
module fmul_round
  import fpu_pkg::*;
#(
  parameter int EXP_W = FP32_EXP_W,
  parameter int MAN_W = FP32_MAN_W
) (
  input  logic                   sign_i,
  input  logic [EXP_W+1:0]       esum_i,
  input  logic [2*MAN_W+1:0]     prod_i,
  input  fp_class_t              cls_a_i,
  input  fp_class_t              cls_b_i,
  output logic [EXP_W+MAN_W:0]   y_o,
  output fp_flags_t              flags_o
);

  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS_V     = EW'(bias(EXP_W));
  localparam logic [EW-1:0] ALL_ONES_V = EW'((1 << EXP_W) - 1);

  logic               norm;
  logic [PW-2:0]      prod_n;
  logic [MAN_W-1:0]   kept;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic [MAN_W:0]     man_rnd;
  logic               carry;
  logic [EW-1:0]      eb;
  logic               invalid;
  logic               any_inf;
  logic               any_zero;

  // Product of two [1,2) significands lies in [1,4): the MSB says which.
  // After the shift the hidden one sits at the top of prod_n and is dropped.
  assign norm   = prod_i[PW-1];
  assign prod_n = norm ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
  assign kept   = prod_n[PW-2 -: MAN_W];
  assign guard  = prod_n[MAN_W];
  assign sticky = |prod_n[MAN_W-1:0];

  // Ties go to the even kept value.
  assign round_up = guard & (sticky | kept[0]);
  assign man_rnd  = {1'b0, kept} + {{MAN_W{1'b0}}, round_up};
  // A carry out means the significand became exactly 2.0; the stored
  // mantissa bits are then all zero, so only the exponent moves.
  assign carry    = man_rnd[MAN_W];

  assign eb = esum_i - BIAS_V + {{(EW-1){1'b0}}, norm} + {{(EW-1){1'b0}}, carry};

  assign invalid  = (cls_a_i == NAN) || (cls_b_i == NAN) ||
                    (cls_a_i == INF && cls_b_i == ZERO) ||
                    (cls_b_i == INF && cls_a_i == ZERO);
  assign any_inf  = (cls_a_i == INF) || (cls_b_i == INF);
  assign any_zero = (cls_a_i == ZERO) || (cls_b_i == ZERO);

  always_comb begin
    y_o     = '0;
    flags_o = '0;
    if (invalid) begin
      y_o        = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flags_o.nv = 1'b1;
    end else if (any_inf) begin
      y_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (any_zero) begin
      y_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
    end else if ($signed(eb) >= $signed(ALL_ONES_V)) begin
      y_o        = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_o.of = 1'b1;
      flags_o.nx = 1'b1;
    end else if ($signed(eb) <= $signed(EW'(0))) begin
      y_o        = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      flags_o.uf = 1'b1;
      flags_o.nx = 1'b1;
    end else begin
      y_o        = {sign_i, eb[EXP_W-1:0], man_rnd[MAN_W-1:0]};
      flags_o.nx = guard | sticky;
    end
  end

endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: elastic, parametrised floating-point multiplier.
//   Stage 1 unpacks, classifies and multiplies significands; stages
//   2..LATENCY-1 only retime that bundle; the last stage rounds and packs.
//   The whole pipe moves as one shift register: it advances whenever the
//   output slot is empty or being consumed, and holds otherwise.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_ready independent of in_valid)
//   x1, x2                : operands {sign, exp, man}
//   out_valid / out_ready : result handshake
//   y                     : product
//   flags                 : {nv, of, uf, nx}, meaningful while out_valid
module fmul_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W   = FP32_EXP_W,
  parameter int MAN_W   = FP32_MAN_W,
  parameter int LATENCY = 2            // legal range 2..4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] x1,
  input  logic [EXP_W+MAN_W:0] x2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] y,
  output logic [3:0]           flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int NS = LATENCY - 1;     // stage 1 plus retiming stages

  typedef struct packed {
    logic            sign;
    logic [EW-1:0]   esum;
    logic [PW-1:0]   prod;
    fp_class_t       cls_a;
    fp_class_t       cls_b;
  } bundle_t;

  logic             advance;
  logic [W-1:0]     op      [2];
  logic [EXP_W-1:0] op_exp  [2];
  logic [MAN_W:0]   op_sig  [2];
  fp_class_t        op_cls  [2];
  bundle_t          s1_d;
  bundle_t          st_q    [NS];
  logic [NS-1:0]    vld_q;
  logic [W-1:0]     y_d;
  fp_flags_t        flags_d;
  logic [W-1:0]     y_q;
  fp_flags_t        flags_q;
  logic             out_valid_q;

  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  assign op[0] = x1;
  assign op[1] = x2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign op_exp[gi] = op[gi][W-2 -: EXP_W];
    // Hidden bit forced to 1; for zero/subnormal operands the product is
    // meaningless but classification overrides it downstream.
    assign op_sig[gi] = {1'b1, op[gi][MAN_W-1:0]};
    assign op_cls[gi] = fp_classify(op_exp[gi] == '0, &op_exp[gi],
                                    op[gi][MAN_W-1:0] == '0);
  end

  always_comb begin
    s1_d       = '0;
    s1_d.sign  = x1[W-1] ^ x2[W-1];
    s1_d.esum  = {2'b00, op_exp[0]} + {2'b00, op_exp[1]};
    s1_d.prod  = PW'(op_sig[0]) * PW'(op_sig[1]);
    s1_d.cls_a = op_cls[0];
    s1_d.cls_b = op_cls[1];
  end

  // Data registers carry no reset: they are only observed through valid bits.
  always_ff @(posedge clk) begin
    if (advance) begin
      st_q[0] <= s1_d;
      for (int i = 1; i < NS; i++) begin
        st_q[i] <= st_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flags_q     <= '0;
    end else if (advance) begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < NS; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      out_valid_q <= vld_q[NS-1];
      y_q         <= y_d;
      flags_q     <= flags_d;
    end
  end

  fmul_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign_i  (st_q[NS-1].sign),
    .esum_i  (st_q[NS-1].esum),
    .prod_i  (st_q[NS-1].prod),
    .cls_a_i (st_q[NS-1].cls_a),
    .cls_b_i (st_q[NS-1].cls_b),
    .y_o     (y_d),
    .flags_o (flags_d)
  );

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: self-checking bench for fmul_pipe (fp32).
//   u_dut2 (LATENCY=2): directed vector table, randomized traffic, reset mid-flight.
//   u_dut4 (LATENCY=4): backpressure sequence.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [31:0] x1_2, x2_2, y2;
  logic [3:0]  flags2;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [31:0] x1_4, x2_4, y4;
  logic [3:0]  flags4;

  int tests = 0;
  int fails = 0;

  fmul_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .x1(x1_2), .x2(x2_2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .y(y2), .flags(flags2)
  );

  fmul_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .x1(x1_4), .x2(x2_4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .y(y4), .flags(flags4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Reference: exact integer product rounded by comparing the discarded
  // remainder against one half, straight from the IEEE rounding rule.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic            s, an, bn, ai, bi, az, bz, nx;
    int              ea, eb, e, sh;
    longint unsigned p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {32'h7FC00000, 4'b1000};
    if (ai || bi) return {s, 8'hFF, 23'd0, 4'b0000};
    if (az || bz) return {s, 31'd0, 4'b0000};
    p  = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = ea + eb - 127 + ((sh == 24) ? 1 : 0);
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    nx   = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 4'b0101};
    if (e <= 0)   return {s, 31'd0, 4'b0011};
    return {s, 8'(e), q[22:0], 3'b000, nx};
  endfunction

  function automatic logic [31:0] rand_op();
    int          r;
    logic [7:0]  e;
    logic [22:0] m;
    r = $urandom_range(0, 9);
    m = 23'($urandom);
    case (r)
      6:       e = 8'h00;
      7:       e = 8'hFF;
      8:       e = 8'($urandom_range(100, 160));
      9:       e = ($urandom_range(0, 1) != 0) ? 8'd1 : 8'd254;
      default: e = 8'($urandom_range(1, 254));
    endcase
    if ($urandom_range(0, 7) == 0) m = '0;
    return {1'($urandom), e, m};
  endfunction

  // One isolated op on u_dut2; reports result and cycles from accept to out_valid.
  task automatic run_single(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] y, output logic [3:0] f, output int lat);
    @(negedge clk);
    in_valid2  = 1'b1;
    x1_2       = a;
    x2_2       = b;
    out_ready2 = 1'b1;
    #1;
    lat = 0;
    y   = 'x;
    f   = 'x;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) in_valid2 = 1'b0;
      #1;
      if (out_valid2) begin
        lat = n;
        y   = y2;
        f   = flags2;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] ry;
    logic [3:0]  rf;
    int          lat;
    logic [35:0] exp_q[$];
    logic [35:0] e;
    logic [31:0] pa, pb;
    bit          pend;
    int          sent, recv;
    logic [31:0] bp_a[8], bp_b[8];
    int          k, got;
    bit          stalled_prev, saw_block;
    logic [31:0] y_prev;
    logic [31:0] r_a[3], r_b[3];

    vecs[0] = '{"basic",     32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1] = '{"rne_tie",   32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};
    vecs[2] = '{"one_one",   32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000};
    vecs[3] = '{"overflow",  32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101};
    vecs[4] = '{"underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
    vecs[5] = '{"neg_uflow", 32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011};
    vecs[6] = '{"inf_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
    vecs[7] = '{"ninf_two",  32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
    vecs[8] = '{"subn_ftz",  32'h00000001, 32'h7F000000, 32'h00000000, 4'b0000};
    vecs[9] = '{"nan_in",    32'h7FC00000, 32'hBF800000, 32'h7FC00000, 4'b1000};

    rst = 1'b1;
    in_valid2 = 1'b0; out_ready2 = 1'b1; x1_2 = '0; x2_2 = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; x1_4 = '0; x2_4 = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid2", {31'd0, out_valid2}, 32'd0);
    check("reset_y2",         y2, 32'd0);
    check("reset_flags2",     {28'd0, flags2}, 32'd0);
    check("reset_out_valid4", {31'd0, out_valid4}, 32'd0);
    check("reset_in_ready2",  {31'd0, in_ready2}, 32'd1);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_single(vecs[i].a, vecs[i].b, ry, rf, lat);
      $display("[TB] vec %s: %08h * %08h -> y=%08h flags=%b lat=%0d",
               vecs[i].name, vecs[i].a, vecs[i].b, ry, rf, lat);
      check({vecs[i].name, "_y"},     ry, vecs[i].y);
      check({vecs[i].name, "_flags"}, {28'd0, rf}, {28'd0, vecs[i].f});
      check({vecs[i].name, "_lat"},   32'(lat), 32'd2);
    end

    // Randomized traffic with random backpressure on u_dut2
    sent = 0; recv = 0; pend = 1'b0;
    for (int c = 0; c < 6000 && recv < 300; c++) begin
      @(negedge clk);
      if (!pend && sent < 300 && $urandom_range(0, 3) != 0) begin
        pa = rand_op();
        pb = rand_op();
        pend = 1'b1;
      end
      in_valid2  = pend;
      x1_2       = pa;
      x2_2       = pb;
      out_ready2 = ($urandom_range(0, 9) < 7);
      #1;
      check("rand_in_ready", {31'd0, in_ready2}, {31'd0, (~out_valid2 | out_ready2)});
      if (in_valid2 && in_ready2) begin
        exp_q.push_back(ref_mul(pa, pb));
        sent++;
        pend = 1'b0;
      end
      if (out_valid2 && out_ready2) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] rand #%0d: y=%08h flags=%b expect y=%08h flags=%b",
                   recv, y2, flags2, e[35:4], e[3:0]);
          check("rand_y",     y2, e[35:4]);
          check("rand_flags", {28'd0, flags2}, {28'd0, e[3:0]});
        end
        recv++;
      end
    end
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    check("rand_all_received", 32'(recv), 32'd300);

    // Backpressure on u_dut4: out_ready low for cycles 3..8
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
      bp_b[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    end
    k = 0; got = 0; stalled_prev = 1'b0; saw_block = 1'b0; y_prev = '0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      @(negedge clk);
      if (k < 8) begin
        in_valid4 = 1'b1;
        x1_4 = bp_a[k];
        x2_4 = bp_b[k];
      end else begin
        in_valid4 = 1'b0;
      end
      out_ready4 = !(c >= 3 && c <= 8);
      #1;
      if (stalled_prev) check("bp_hold_y", y4, y_prev);
      if (in_valid4 && !in_ready4) saw_block = 1'b1;
      if (in_valid4 && in_ready4) k++;
      if (out_valid4 && out_ready4) begin
        e = ref_mul(bp_a[got], bp_b[got]);
        $display("[TB] bp #%0d: y=%08h expect %08h", got, y4, e[35:4]);
        check("bp_y",     y4, e[35:4]);
        check("bp_flags", {28'd0, flags4}, {28'd0, e[3:0]});
        got++;
      end
      stalled_prev = out_valid4 && !out_ready4;
      y_prev = y4;
    end
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    check("bp_count",    32'(got), 32'd8);
    check("bp_accepted", 32'(k), 32'd8);
    check("bp_in_ready_dropped", {31'd0, saw_block}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      check("bp_no_duplicate", {31'd0, out_valid4}, 32'd0);
    end

    // Reset mid-flight on u_dut2
    r_a[0] = 32'h40000000; r_b[0] = 32'h40400000;   // 6.0
    r_a[1] = 32'h3FC00000; r_b[1] = 32'h3FC00000;   // 2.25
    r_a[2] = 32'hC0800000; r_b[2] = 32'h40000000;   // -8.0
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid2 = 1'b1; x1_2 = r_a[c]; x2_2 = r_b[c]; out_ready2 = 1'b1;
      #1;
      check("rst_accept", {31'd0, in_ready2}, 32'd1);
      if (c == 2) check("rst_first_result", y2, 32'h40C00000);
    end
    @(negedge clk);
    in_valid2 = 1'b0; out_ready2 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready2 = 1'b1;
    #1;
    $display("[TB] reset mid-flight: out_valid=%b y=%08h", out_valid2, y2);
    check("rst_out_valid", {31'd0, out_valid2}, 32'd0);
    check("rst_y",         y2, 32'd0);
    check("rst_flags",     {28'd0, flags2}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("rst_no_stale", {31'd0, out_valid2}, 32'd0);
    end
    run_single(32'h40400000, 32'h40400000, ry, rf, lat);
    $display("[TB] post-reset op: y=%08h flags=%b lat=%0d", ry, rf, lat);
    check("rst_new_y",   ry, 32'h41100000);
    check("rst_new_lat", 32'(lat), 32'd2);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
